// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR sequencer
package lfsr_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_SEED = 2'd0,
        OP_RUN_BURST = 2'd1,
        OP_ABORT     = 2'd2,
        OP_RSVD      = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // x^4 + x^3 + 1, maximal length 15
    localparam logic [3:0] LFSR_TAPS         = 4'b1100;
    localparam logic [3:0] LFSR_DEFAULT_SEED = 4'b0001;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - bare Fibonacci shift register with load and step
module lfsr_core #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    // Load wins over step; the register only moves on one of the two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - command-driven burst sequencer around lfsr_core
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             lockup_err,
    output logic [CNT_W-1:0] remaining
);

    state_e           state, state_n;
    logic [CNT_W-1:0] remaining_n;
    logic             lockup_n;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             step;
    logic             cmd_fire;
    logic             beat;
    op_e              op;

    assign op        = op_e'(cmd_op);
    assign out_valid = (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    // In RUN only an abort may be taken; everything else stalls the master.
    assign cmd_ready = (state == ST_IDLE) || (op == OP_ABORT);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat      = out_valid && out_ready;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .q        (out_data)
    );

    // State, burst counter and sticky lockup flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            lockup_err <= 1'b0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            lockup_err <= lockup_n;
        end
    end

    // Next-state, counter update and LFSR load/step requests.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        lockup_n    = lockup_err;
        load        = 1'b0;
        load_val    = DEFAULT_SEED;
        step        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (op)
                        OP_LOAD_SEED: begin
                            load = 1'b1;
                            if (cmd_data[WIDTH-1:0] == '0) begin
                                // Zero would lock the LFSR; substitute and flag it.
                                load_val = DEFAULT_SEED;
                                lockup_n = 1'b1;
                            end else begin
                                load_val = cmd_data[WIDTH-1:0];
                                lockup_n = 1'b0;
                            end
                        end
                        OP_RUN_BURST: begin
                            if (cmd_data != '0) begin
                                state_n     = ST_RUN;
                                remaining_n = cmd_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (beat) begin
                    step = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_n     = ST_IDLE;
                        remaining_n = '0;
                    end else begin
                        remaining_n = remaining - CNT_W'(1);
                    end
                end
                // A same-cycle beat has already stepped the LFSR above.
                if (cmd_fire) begin
                    state_n     = ST_IDLE;
                    remaining_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - self-checking bench for lfsr_seq_ctrl
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;
    logic       lockup_err;
    logic [7:0] remaining;

    always #5 clk = ~clk;

    lfsr_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .lockup_err (lockup_err),
        .remaining  (remaining)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Maximal-length sequence from seed 1, taken directly from the x^4+x^3+1 polynomial
    int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    typedef struct {
        logic       cv;
        logic [1:0] op;
        logic [7:0] d;
        logic       ordy;
        logic       crdy;
        logic [3:0] q;
        logic       ov;
        logic [7:0] rem;
        logic       lock;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic [7:0] d, input logic ordy);
        reset     = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input int v);
        for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
        return 0;
    endfunction

    // Reference model: LFSR tracked as a position in the known sequence
    int m_idx;
    bit m_run;
    int m_rem;
    bit m_lock;

    initial begin
        drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        tick();
        check("reset_q", out_data, 1);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rem", remaining, 0);
        check("reset_lock", lockup_err, 0);

        // Full-period burst
        drive(1'b1, 1'b1, 2'd1, 8'd15, 1'b1);
        #1 check("b15_crdy", cmd_ready, 1);
        tick();
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            check("b15_valid", out_valid, 1);
            check($sformatf("b15_beat%0d", i), out_data, seq[i]);
            tick();
        end
        check("b15_busy_end", busy, 0);
        check("b15_q_end", out_data, 1);

        // Lockup handling and backpressure burst
        tbl[0] = '{1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b0, 8'd0, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 8'h09, 1'b0, 1'b1, 4'h9, 1'b0, 8'd0, 1'b0};
        tbl[2] = '{1'b1, 2'd1, 8'd4,  1'b0, 1'b1, 4'h9, 1'b1, 8'd4, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'h3, 1'b1, 8'd3, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'h3, 1'b1, 8'd3, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'h3, 1'b1, 8'd3, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'h6, 1'b1, 8'd2, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'hD, 1'b1, 8'd1, 1'b0};
        tbl[8] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'hD, 1'b1, 8'd1, 1'b0};
        tbl[9] = '{1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'hA, 1'b0, 8'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].cv, tbl[i].op, tbl[i].d, tbl[i].ordy);
            #1 check($sformatf("tbl%0d_crdy", i), cmd_ready, tbl[i].crdy);
            tick();
            check($sformatf("tbl%0d_q", i), out_data, tbl[i].q);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].ov);
            check($sformatf("tbl%0d_rem", i), remaining, tbl[i].rem);
            check($sformatf("tbl%0d_lock", i), lockup_err, tbl[i].lock);
        end

        // Abort after 3 beats with a 4th beat in the same cycle; LOAD stalls in RUN
        drive(1'b1, 1'b1, 2'd1, 8'd10, 1'b1);
        tick();
        check("ab_first_beat", out_data, 4'hA);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'd0, 8'd5, 1'b1);
            #1 check("ab_load_stall", cmd_ready, 0);
            tick();
        end
        check("ab_rem_before", remaining, 7);
        drive(1'b1, 1'b1, 2'd2, 8'd0, 1'b1);
        #1 check("ab_crdy", cmd_ready, 1);
        tick();
        check("ab_valid", out_valid, 0);
        check("ab_rem", remaining, 0);
        check("ab_q", out_data, 4'hF);
        check("ab_lock", lockup_err, 0);

        // Zero-length burst
        drive(1'b1, 1'b1, 2'd1, 8'd0, 1'b1);
        #1 check("n0_crdy", cmd_ready, 1);
        tick();
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("n0_valid", out_valid, 0);
            tick();
        end
        check("n0_q", out_data, 4'hF);

        // Reset in the middle of a burst
        drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 2'd1, 8'd7, 1'b1);
        tick();
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
        tick();
        tick();
        check("mid_rem", remaining, 5);
        check("mid_q", out_data, 4);
        check("mid_lock", lockup_err, 1);
        drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_rem", remaining, 0);
        check("rst_q", out_data, 1);
        check("rst_lock", lockup_err, 0);
        check("rst_busy", busy, 0);

        // Randomized run against the sequence-position model
        m_idx = 0; m_run = 0; m_rem = 0; m_lock = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       r, v, ordy;
            logic [1:0] op;
            logic [7:0] d;
            bit         rdy_m, fire, beat;
            r    = ($urandom_range(0, 63) != 0);
            v    = $urandom_range(0, 1);
            op   = 2'($urandom_range(0, 3));
            if (op == 2'd1) d = 8'($urandom_range(0, 20));
            else d = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ordy = ($urandom_range(0, 3) != 0);
            drive(r, v, op, d, ordy);
            rdy_m = !m_run || (op == 2'd2);
            #1 check("rnd_crdy", cmd_ready, rdy_m);
            fire = v && rdy_m;
            beat = m_run && ordy;
            if (!r) begin
                m_idx = 0; m_run = 0; m_rem = 0; m_lock = 0;
            end else if (!m_run) begin
                if (fire && op == 2'd0) begin
                    if (d % 16 == 0) begin
                        m_idx = 0; m_lock = 1;
                    end else begin
                        m_idx = idx_of(d % 16); m_lock = 0;
                    end
                end else if (fire && op == 2'd1 && d != 0) begin
                    m_run = 1; m_rem = d;
                end
            end else begin
                if (beat) begin
                    m_idx = (m_idx + 1) % 15;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_run = 0;
                end
                if (fire) begin
                    m_run = 0; m_rem = 0;
                end
            end
            tick();
            check("rnd_q", out_data, seq[m_idx]);
            check("rnd_valid", out_valid, m_run);
            check("rnd_busy", busy, m_run);
            check("rnd_rem", remaining, m_rem);
            check("rnd_lock", lockup_err, m_lock);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
